// File: rtl/tcm_ram_obi.sv
// ---------------------------------------------------------------------------
// tcm_ram_obi
// Single-port tightly coupled memory with an OBI-style req/gnt/rvalid slave
// port, programmable grant wait states, fixed response latency, byte enables,
// out-of-range error responses and an end-of-test mailbox.
//
// Ports
//   clk        : clock (single domain)
//   rst_n      : synchronous active-low reset
//   req_i      : request
//   gnt_o      : grant (combinational); a request is accepted on req_i && gnt_o
//   addr_i     : byte address; word index is addr_i[ADDR_WIDTH-1:log2(BE_WIDTH)]
//   we_i       : write enable
//   be_i       : byte enables
//   wdata_i    : write data
//   rvalid_o   : response valid, one pulse per accepted request
//   rdata_o    : read data (0 for writes and errors)
//   err_o      : response error, qualified by rvalid_o
//   done_o     : sticky completion flag
//   result_o   : RESULT_WORD content captured at completion
//   cycles_o   : cycles from reset release until done_o
// ---------------------------------------------------------------------------
module tcm_ram_obi #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_WORDS   = 512,
   parameter int GNT_WAIT    = 0,
   parameter int RD_LATENCY  = 1,
   parameter int MBOX_EN     = 1,
   parameter int DONE_WORD   = 0,
   parameter int RESULT_WORD = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o,
   output logic                    done_o,
   output logic [DATA_WIDTH-1:0]   result_o,
   output logic [31:0]             cycles_o
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int OFFS     = $clog2(BE_WIDTH);
   localparam int IDX_W    = ADDR_WIDTH - OFFS;
   localparam int MEM_AW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   // Storage: intentionally never reset so preloaded images survive reset.
   logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

   logic [3:0]            wait_cnt_q;
   logic [3:0]            wait_cnt_d;

   // Response pipeline: stage 0 is loaded at the grant edge.
   logic                  pv_q [RD_LATENCY];
   logic                  pe_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];

   logic                  done_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [31:0]           cycles_q;

   logic [IDX_W-1:0]      word_idx_s;
   logic [MEM_AW-1:0]     mem_idx_s;
   logic                  oob_s;
   logic                  gnt_s;
   logic                  acc_s;
   logic                  wr_en_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] rsp_data_s;
   logic [DATA_WIDTH-1:0] res_word_s;
   logic                  trigger_s;

   assign word_idx_s = addr_i[ADDR_WIDTH-1:OFFS];
   assign mem_idx_s  = word_idx_s[MEM_AW-1:0];
   // Zero-extend so the comparison is exact for any index width.
   assign oob_s      = ({{(64-IDX_W){1'b0}}, word_idx_s} >= 64'(NUM_WORDS));

   assign gnt_s   = req_i && (wait_cnt_q == 4'(GNT_WAIT));
   assign gnt_o   = gnt_s;
   assign acc_s   = req_i && gnt_s;
   // Writes are suppressed while reset is asserted, even if granted.
   assign wr_en_s = acc_s && we_i && !oob_s && rst_n;

   assign rd_word_s = mem_q[mem_idx_s];

   // Next wait-state count: restart on drop or acceptance, else count up to GNT_WAIT.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!req_i || acc_s) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q < 4'(GNT_WAIT)) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // Wait-state counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_q <= 4'd0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Memory array write with per-lane byte enables.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (be_i[b]) begin
               mem_q[mem_idx_s][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   // Response payload: read data only for in-range reads.
   always_comb begin
      rsp_data_s = {DATA_WIDTH{1'b0}};
      if (!we_i && !oob_s) begin
         rsp_data_s = rd_word_s;
      end else begin
         rsp_data_s = {DATA_WIDTH{1'b0}};
      end
   end

   // Response shift register carrying {valid, err, data}.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pv_q[i] <= 1'b0;
            pe_q[i] <= 1'b0;
            pd_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         pv_q[0] <= acc_s;
         pe_q[0] <= acc_s && oob_s;
         pd_q[0] <= acc_s ? rsp_data_s : {DATA_WIDTH{1'b0}};
         for (int i = 1; i < RD_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
      end
   end

   assign rvalid_o = pv_q[RD_LATENCY-1];
   assign err_o    = pe_q[RD_LATENCY-1];
   assign rdata_o  = pd_q[RD_LATENCY-1];

   // Result word as it will look after this edge, merging a same-grant write.
   always_comb begin
      res_word_s = mem_q[RESULT_WORD];
      if (wr_en_s && (word_idx_s == IDX_W'(RESULT_WORD))) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (be_i[b]) begin
               res_word_s[b*8 +: 8] = wdata_i[b*8 +: 8];
            end else begin
               res_word_s[b*8 +: 8] = mem_q[RESULT_WORD][b*8 +: 8];
            end
         end
      end else begin
         res_word_s = mem_q[RESULT_WORD];
      end
   end

   assign trigger_s = (MBOX_EN != 0) && wr_en_s &&
                      (word_idx_s == IDX_W'(DONE_WORD)) &&
                      be_i[0] && wdata_i[0];

   // Mailbox and cycle counter: count until the first trigger, then freeze.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_q   <= 1'b0;
         result_q <= {DATA_WIDTH{1'b0}};
         cycles_q <= 32'd0;
      end else if (!done_q) begin
         if (cycles_q != 32'hFFFF_FFFF) begin
            cycles_q <= cycles_q + 32'd1;
         end
         if (trigger_s) begin
            done_q   <= 1'b1;
            result_q <= res_word_s;
         end
      end
   end

   assign done_o   = done_q;
   assign result_o = result_q;
   assign cycles_o = cycles_q;

endmodule

// File: tb/tb_tcm_ram_obi.sv
// Directed bench for tcm_ram_obi with a response scoreboard.
// Three instances cover the parameter sets needed:
//   0: GNT_WAIT=0 RD_LATENCY=1 NUM_WORDS=256 (back-to-back, byte enables, OOB, mailbox)
//   1: GNT_WAIT=3 RD_LATENCY=4 NUM_WORDS=512 (wait states / latency)
//   2: GNT_WAIT=0 RD_LATENCY=3 NUM_WORDS=512 (reset with reads in flight)
module tb_tcm_ram_obi;

   localparam int GW  [3] = '{0, 3, 0};
   localparam int LAT [3] = '{1, 4, 3};
   localparam int NW  [3] = '{256, 512, 512};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req    [3];
   logic        gnt    [3];
   logic [31:0] addr   [3];
   logic        we     [3];
   logic [3:0]  be     [3];
   logic [31:0] wdata  [3];
   logic        rvalid [3];
   logic [31:0] rdata  [3];
   logic        err    [3];
   logic        done   [3];
   logic [31:0] result [3];
   logic [31:0] cycles [3];

   typedef struct {
      int          k;
      logic [31:0] data;
      logic        err;
      int          due;
   } rsp_t;

   rsp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   live     = 0;
   int   exp_cyc;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      tcm_ram_obi #(
         .ADDR_WIDTH (32),
         .DATA_WIDTH (32),
         .NUM_WORDS  (NW[k]),
         .GNT_WAIT   (GW[k]),
         .RD_LATENCY (LAT[k]),
         .MBOX_EN    (1),
         .DONE_WORD  (0),
         .RESULT_WORD(1)
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .req_i   (req[k]),
         .gnt_o   (gnt[k]),
         .addr_i  (addr[k]),
         .we_i    (we[k]),
         .be_i    (be[k]),
         .wdata_i (wdata[k]),
         .rvalid_o(rvalid[k]),
         .rdata_o (rdata[k]),
         .err_o   (err[k]),
         .done_o  (done[k]),
         .result_o(result[k]),
         .cycles_o(cycles[k])
      );
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) live <= live + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard monitor: every rvalid pulse must match the oldest expectation.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rvalid[k] === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_rvalid", 64'(k), 64'hFF);
            end else begin
               rsp_t e;
               e = sb.pop_front();
               chk("rsp_port", 64'(k), 64'(e.k));
               chk("rsp_rdata", {32'd0, rdata[k]}, {32'd0, e.data});
               chk("rsp_err", {63'd0, err[k]}, {63'd0, e.err});
               chk("rsp_cycle", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
      int   waits;
      rsp_t r;
      req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
      waits = 0;
      @(negedge clk);
      while (gnt[k] !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      chk("gnt_wait", 64'(waits), 64'(GW[k]));
      if (gnt[k] === 1'b1) begin
         r.k = k; r.data = exp_d; r.err = exp_e; r.due = cyc + LAT[k];
         sb.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k, input int n);
      req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; be[k] = 4'h0; wdata[k] = 32'd0;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      req[0] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_rvalid", {63'd0, rvalid[k]}, 64'd0);
         chk("rst_rdata", {32'd0, rdata[k]}, 64'd0);
         chk("rst_err", {63'd0, err[k]}, 64'd0);
         chk("rst_done", {63'd0, done[k]}, 64'd0);
         chk("rst_result", {32'd0, result[k]}, 64'd0);
         chk("rst_cycles", {32'd0, cycles[k]}, 64'd0);
      end
      chk("rst_gnt_req", {63'd0, gnt[0]}, 64'd1);
      chk("rst_gnt_noreq", {63'd0, gnt[1]}, 64'd0);
      @(posedge clk); #1;
      req[0] = 1'b0;
      rst_n = 1'b1;

      // Zero-wait back-to-back write then read.
      xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
      idle(0, 3);

      // Byte enables.
      xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0);
      xfer(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0);
      xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0);
      idle(0, 3);

      // Out of range: word 256 of a 256-word memory; word 0 must not alias.
      xfer(0, 1'b1, 32'h0, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0);
      xfer(0, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
      xfer(0, 1'b0, 32'h400, 4'hF, 32'h0, 32'h0, 1'b1);
      xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0);
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
      idle(0, 3);
      chk("oob_no_done", {63'd0, done[0]}, 64'd0);

      // Wait states and latency on instance 1.
      xfer(1, 1'b1, 32'h40, 4'hF, 32'h600DCAFE, 32'h0, 1'b0);
      idle(1, 6);
      xfer(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h600DCAFE, 1'b0);
      idle(1, 8);

      // Mailbox on instance 0.
      xfer(0, 1'b1, 32'h4, 4'hF, 32'd120, 32'h0, 1'b0);
      chk("mbox_pre_done", {63'd0, done[0]}, 64'd0);
      xfer(0, 1'b1, 32'h0, 4'hF, 32'd1, 32'h0, 1'b0);
      exp_cyc = live;
      chk("mbox_done", {63'd0, done[0]}, 64'd1);
      chk("mbox_result", {32'd0, result[0]}, 64'd120);
      chk("mbox_cycles", {32'd0, cycles[0]}, 64'(exp_cyc));
      idle(0, 5);
      chk("mbox_cycles_frozen", {32'd0, cycles[0]}, 64'(exp_cyc));
      xfer(0, 1'b1, 32'h4, 4'hF, 32'd7, 32'h0, 1'b0);
      xfer(0, 1'b1, 32'h0, 4'hF, 32'd1, 32'h0, 1'b0);
      xfer(0, 1'b0, 32'h4, 4'hF, 32'h0, 32'd7, 1'b0);
      idle(0, 4);
      chk("mbox_no_relatch", {32'd0, result[0]}, 64'd120);
      chk("mbox_cycles_final", {32'd0, cycles[0]}, 64'(exp_cyc));

      // Reset with two reads in flight on instance 2; a write granted in reset is dropped.
      xfer(2, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 32'h0, 1'b0);
      xfer(2, 1'b1, 32'h24, 4'hF, 32'h12345678, 32'h0, 1'b0);
      idle(2, 5);
      xfer(2, 1'b0, 32'h20, 4'hF, 32'h0, 32'h0BADF00D, 1'b0);
      xfer(2, 1'b0, 32'h24, 4'hF, 32'h0, 32'h12345678, 1'b0);
      req[2] = 1'b0;
      rst_n = 1'b0;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; be[0] = 4'hF; wdata[0] = 32'h0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      req[0] = 1'b0; we[0] = 1'b0;
      sb.delete();
      chk("rst2_done", {63'd0, done[0]}, 64'd0);
      chk("rst2_cycles", {32'd0, cycles[0]}, 64'd0);
      chk("rst2_result", {32'd0, result[0]}, 64'd0);
      chk("rst2_rvalid", {63'd0, rvalid[2]}, 64'd0);
      idle(2, 8);
      xfer(2, 1'b0, 32'h20, 4'hF, 32'h0, 32'h0BADF00D, 1'b0);
      xfer(2, 1'b0, 32'h24, 4'hF, 32'h0, 32'h12345678, 1'b0);
      idle(2, 5);
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
      idle(0, 5);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/tcm_ram_obi.md
# tcm_ram_obi

Parametrised single-port tightly coupled memory with an OBI-style req/gnt/rvalid slave port, programmable grant wait states, fixed read latency, byte enables, out-of-range error response and a built-in end-of-test mailbox. It sits beside `cevero_ft_core` as instruction or data memory in the SoC and regression benches. It replaces the fixed zero-wait `sp_ram` so benches can stress fetch and LSU stall paths and detect completion in hardware rather than by peeking at memory words.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data width. Must be a multiple of 8; `BE_WIDTH = DATA_WIDTH/8`.
- `NUM_WORDS`, 512: memory depth in words.
- `GNT_WAIT`, 0: cycles `req_i` must be held before `gnt_o` rises (0..15).
- `RD_LATENCY`, 1: cycles from grant edge to `rvalid_o` (1..8).
- `MBOX_EN`, 1: enables the end-of-test mailbox.
- `DONE_WORD`, 0: word index of the completion flag.
- `RESULT_WORD`, 1: word index of the result.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_i` in 1: request.
- `gnt_o` out 1: grant. Request is accepted on a cycle with `req_i && gnt_o`.
- `addr_i` in ADDR_WIDTH: byte address. Word index is `addr_i[ADDR_WIDTH-1:log2(BE_WIDTH)]`.
- `we_i` in 1: write enable.
- `be_i` in BE_WIDTH: byte enables.
- `wdata_i` in DATA_WIDTH: write data.
- `rvalid_o` out 1: response valid, a one-cycle pulse per accepted request.
- `rdata_o` out DATA_WIDTH: read data. 0 for writes and errors.
- `err_o` out 1: response error, qualified by `rvalid_o`.
- `done_o` out 1: sticky completion flag.
- `result_o` out DATA_WIDTH: result captured at completion.
- `cycles_o` out 32: cycles from reset release until `done_o`.

## Operation
- **Wait counter.** `wait_cnt` (4 bits) increments each cycle `req_i` is high and `wait_cnt < GNT_WAIT`.
  - `gnt_o = req_i && (wait_cnt == GNT_WAIT)`, combinational.
  - `wait_cnt` clears on an accepted request or when `req_i` drops.
  - With `GNT_WAIT=0`, the port grants in the same cycle as the request.
- **Range check.** `oob` = word index >= `NUM_WORDS`.
- **Accepted write, in range.** Each byte lane with `be_i` set is written at the grant edge. Lanes with `be_i` clear keep their value.
- **Accepted write, out of range.** Memory is untouched and the response has `err_o=1`.
- **Accepted read.** The word is sampled at the grant edge. An out-of-range read returns `rdata_o=0` with `err_o=1`.
- **Response pipeline.** A shift register of depth `RD_LATENCY` carries `{valid, err, data}`.
  - One request can be accepted every cycle, and responses return strictly in order.
  - No backpressure: the master must always accept `rvalid_o`.
- **Read-during-write.** Not possible on a single port. Back-to-back write then read of the same word returns the new data.
- **Mailbox** (only when `MBOX_EN=1`).
  - Trigger: an accepted in-range write to `DONE_WORD` with `be_i[0]=1` and `wdata_i[0]=1`.
  - The cycle after the trigger, `done_o` goes high and stays high until reset.
  - `result_o` latches the content of `RESULT_WORD` as of that cycle, including a write to it in the same grant.
  - Later triggers do not re-latch.
- **Cycle counter.** `cycles_o` increments every cycle after reset release while `done_o=0`, saturating at `32'hFFFF_FFFF`, and freezes once `done_o` rises.
- **Reset.**
  - Memory array is not reset; benches preload it with `$readmemb`.
  - Reset clears `wait_cnt`, the response pipeline, `done_o`, `result_o` and `cycles_o`.

## Timing
- **Reset values.** `gnt_o` follows `req_i` per the rule above. `rvalid_o=0`, `rdata_o=0`, `err_o=0`, `done_o=0`, `result_o=0`, `cycles_o=0`.
- **Grant latency.** `gnt_o` rises `GNT_WAIT` cycles after `req_i` first rises. The master holds `req_i`, `addr_i`, `we_i`, `be_i` and `wdata_i` stable until granted.
- **Response latency.** `rvalid_o` is high exactly `RD_LATENCY` cycles after the grant edge. Throughput is 1 per cycle when `GNT_WAIT=0`, else 1 per `GNT_WAIT+1` cycles.
- **Reset mid-operation.** In-flight responses are dropped, so no `rvalid_o` appears after the reset edge. A write granted in the same cycle that `rst_n` is low is not performed.
- **Completion timing.** `done_o` and `result_o` change together, one cycle after the trigger grant. `cycles_o` value = number of rising edges with `rst_n=1` before `done_o` rose.

## Test plan
1. **Zero-wait back-to-back.** `GNT_WAIT=0`, `RD_LATENCY=1`: write `32'hDEADBEEF` to byte address 0x10, then read 0x10 next cycle -> both granted in the same cycle as the request; read `rvalid_o` one cycle after its grant with `rdata_o=32'hDEADBEEF`, `err_o=0`.
2. **Wait states and latency.** `GNT_WAIT=3`, `RD_LATENCY=4`: read of a preloaded word -> `gnt_o` 3 cycles after `req_i` rises; `rvalid_o` 4 cycles after the grant; exactly one pulse.
3. **Byte enables.** Word holds `32'h11223344`; write `32'hAABBCCDD` with `be_i=4'b0101`, then read -> `32'h11BB33DD`.
4. **Out of range.** `NUM_WORDS=256`: write to 0x400, then read 0x400 -> both responses have `err_o=1`; the read returns `rdata_o=0`; no in-range word changes.
5. **Mailbox.** Write `120` to word 1, then `1` to word 0 at cycle N after reset release -> `done_o=1` and `result_o=120` at N+1; `cycles_o` frozen; a second write of 1 to word 0 leaves `result_o` unchanged.
6. **Reset mid-stream.** `RD_LATENCY=3`: assert `rst_n=0` for one cycle while two reads are in flight -> no `rvalid_o` afterwards; `done_o=0` and `cycles_o=0`; memory contents preserved.
